// File: rtl/synth_pkg.sv
// Shared types and constants for the oscillator bank: wave types, register map,
// LFSR configuration and a ceil-log2 helper.
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'b00,
    WAVE_SQUARE = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_NOISE  = 2'b11
  } wave_e;

  localparam int unsigned REG_STRIDE = 8;

  localparam logic [2:0] OFF_INCR_LO = 3'd0;
  localparam logic [2:0] OFF_GATE    = 3'd1;
  localparam logic [2:0] OFF_WAVE    = 3'd2;
  localparam logic [2:0] OFF_PW      = 3'd3;
  localparam logic [2:0] OFF_INCR_HI = 3'd4;

  localparam int unsigned LFSR_W     = 16;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam int unsigned LFSR_TAP_A = 16;
  localparam int unsigned LFSR_TAP_B = 14;
  localparam int unsigned LFSR_TAP_C = 13;
  localparam int unsigned LFSR_TAP_D = 11;

  // Per-voice register file entry; gate[0] = gate, gate[1] = phase-reset-on-gate
  typedef struct packed {
    logic [7:0] incr_hi;
    logic [7:0] incr_lo;
    logic [7:0] pulse_width;
    wave_e      wave;
    logic [1:0] gate;
  } voice_regs_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/osc_bank_if.sv
// Strobe-based register bus between the host and the oscillator bank.
interface osc_bank_if;
  logic [15:0] BusAddress;
  logic [7:0]  BusWriteData;
  logic [7:0]  BusReadData;
  logic        BusReadWrite;
  logic        BusClock;

  modport master (
    output BusAddress, BusWriteData, BusReadWrite, BusClock,
    input  BusReadData
  );

  modport slave (
    input  BusAddress, BusWriteData, BusReadWrite, BusClock,
    output BusReadData
  );
endinterface

// File: rtl/synth_voice.sv
// One oscillator voice: phase accumulator with gate-triggered phase reset,
// carry-clocked noise LFSR and a registered waveform shaper.
module synth_voice
  import synth_pkg::*;
#(
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned VOICE_IDX = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gate,
  input  logic             phase_clr,
  input  wave_e            wave,
  input  logic [7:0]       pulse_width,
  input  logic [ACC_W-1:0] incr,
  output logic [OUT_W-1:0] sample
);

  localparam logic [LFSR_W-1:0] LFSR_INIT = LFSR_SEED ^ LFSR_W'(VOICE_IDX);

  logic [ACC_W-1:0]  phase_q, phase_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [OUT_W-1:0]  sample_q, sample_d;

  logic [ACC_W:0]    acc_sum_c;
  logic              lfsr_fb_c;
  logic [OUT_W-1:0]  p_c;
  logic [7:0]        p8_c;
  logic [OUT_W-1:0]  p_shl_c;
  logic [OUT_W-1:0]  shaped_c;

  // Accumulate while gated; a qualifying gate write overrides the accumulate
  always_comb begin
    acc_sum_c = {1'b0, phase_q} + {1'b0, incr};
    lfsr_fb_c = lfsr_q[LFSR_TAP_A-1] ^ lfsr_q[LFSR_TAP_B-1] ^
                lfsr_q[LFSR_TAP_C-1] ^ lfsr_q[LFSR_TAP_D-1];
    phase_d   = phase_q;
    lfsr_d    = lfsr_q;
    if (phase_clr) begin
      phase_d = '0;
    end else if (gate) begin
      phase_d = acc_sum_c[ACC_W-1:0];
      if (acc_sum_c[ACC_W]) lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb_c};
    end
  end

  always_comb begin
    p_c      = phase_q[ACC_W-1 -: OUT_W];
    p8_c     = phase_q[ACC_W-1 -: 8];
    p_shl_c  = p_c << 1;
    shaped_c = '0;
    case (wave)
      WAVE_SAW:    shaped_c = p_c;
      WAVE_SQUARE: shaped_c = (p8_c < pulse_width) ? '1 : '0;
      WAVE_TRI:    shaped_c = p_c[OUT_W-1] ? ~p_shl_c : p_shl_c;
      WAVE_NOISE:  shaped_c = lfsr_q[LFSR_W-1 -: OUT_W];
      default:     shaped_c = '0;
    endcase
    sample_d = gate ? shaped_c : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= '0;
      lfsr_q   <= LFSR_INIT;
      sample_q <= '0;
    end else begin
      phase_q  <= phase_d;
      lfsr_q   <= lfsr_d;
      sample_q <= sample_d;
    end
  end

  assign sample = sample_q;

endmodule

// File: rtl/osc_bank.sv
// Multi-voice oscillator bank: bus strobe synchroniser, register file with
// readback, VOICES voice instances and an averaging mixer.
module osc_bank
  import synth_pkg::*;
#(
  parameter int unsigned VOICES    = 4,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned ACC_W     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0010
) (
  input  logic              Clock,
  input  logic              Reset,
  osc_bank_if.slave         bus,
  output logic [OUT_W-1:0]  Waveform,
  output logic [VOICES-1:0] VoiceActive
);

  localparam int unsigned LOG2V    = clog2(VOICES);
  localparam int unsigned MIX_W    = OUT_W + LOG2V;
  localparam int unsigned MAP_SPAN = REG_STRIDE * VOICES;

  logic bclk_s1_q, bclk_s1_d;
  logic bclk_s2_q, bclk_s2_d;
  logic bclk_s3_q, bclk_s3_d;

  voice_regs_t       regs_q [VOICES];
  voice_regs_t       regs_d [VOICES];
  logic [7:0]        rdata_q, rdata_d;
  logic [OUT_W-1:0]  mix_q, mix_d;
  logic [VOICES-1:0] active_q, active_d;

  logic [15:0]       off_c;
  logic              hit_c;
  logic              wr_c;
  logic [VOICES-1:0] phase_clr_c;
  logic [MIX_W-1:0]  mix_sum_c;
  logic [OUT_W-1:0]  voice_sample [VOICES];

  // Strobe crosses into Clock via two flops; third flop forms the edge detector
  always_comb begin
    bclk_s1_d = bus.BusClock;
    bclk_s2_d = bclk_s1_q;
    bclk_s3_d = bclk_s2_q;
    off_c     = bus.BusAddress - BASE_ADDR;
    hit_c     = (bus.BusAddress >= BASE_ADDR) && (off_c < 16'(MAP_SPAN));
    wr_c      = bclk_s2_q && !bclk_s3_q && bus.BusReadWrite && hit_c;
  end

  always_comb begin
    phase_clr_c = '0;
    for (int unsigned v = 0; v < VOICES; v++) begin
      regs_d[v] = regs_q[v];
      if (wr_c && (off_c[15:3] == 13'(v))) begin
        case (off_c[2:0])
          OFF_INCR_LO: regs_d[v].incr_lo     = bus.BusWriteData;
          OFF_GATE: begin
            regs_d[v].gate = bus.BusWriteData[1:0];
            phase_clr_c[v] = !regs_q[v].gate[0] && bus.BusWriteData[0] && bus.BusWriteData[1];
          end
          OFF_WAVE:    regs_d[v].wave        = wave_e'(bus.BusWriteData[1:0]);
          OFF_PW:      regs_d[v].pulse_width = bus.BusWriteData;
          OFF_INCR_HI: regs_d[v].incr_hi     = bus.BusWriteData;
          default:     ;
        endcase
      end
    end
  end

  // Readback follows BusAddress every cycle; reserved and unmapped read as zero
  always_comb begin
    rdata_d = 8'h00;
    for (int unsigned v = 0; v < VOICES; v++) begin
      if (hit_c && (off_c[15:3] == 13'(v))) begin
        case (off_c[2:0])
          OFF_INCR_LO: rdata_d = regs_q[v].incr_lo;
          OFF_GATE:    rdata_d = {6'b0, regs_q[v].gate};
          OFF_WAVE:    rdata_d = {6'b0, regs_q[v].wave};
          OFF_PW:      rdata_d = regs_q[v].pulse_width;
          OFF_INCR_HI: rdata_d = regs_q[v].incr_hi;
          default:     rdata_d = 8'h00;
        endcase
      end
    end
  end

  always_comb begin
    mix_sum_c = '0;
    active_d  = '0;
    for (int unsigned v = 0; v < VOICES; v++) begin
      mix_sum_c   = mix_sum_c + MIX_W'(voice_sample[v]);
      active_d[v] = regs_q[v].gate[0];
    end
    mix_d = OUT_W'(mix_sum_c >> LOG2V);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_s3_q <= 1'b0;
      for (int unsigned v = 0; v < VOICES; v++) regs_q[v] <= '0;
      rdata_q   <= 8'h00;
      mix_q     <= '0;
      active_q  <= '0;
    end else begin
      bclk_s1_q <= bclk_s1_d;
      bclk_s2_q <= bclk_s2_d;
      bclk_s3_q <= bclk_s3_d;
      for (int unsigned v = 0; v < VOICES; v++) regs_q[v] <= regs_d[v];
      rdata_q   <= rdata_d;
      mix_q     <= mix_d;
      active_q  <= active_d;
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_voice
    synth_voice #(
      .ACC_W     (ACC_W),
      .OUT_W     (OUT_W),
      .VOICE_IDX (g)
    ) u_voice (
      .clk         (Clock),
      .rst_n       (Reset),
      .gate        (regs_q[g].gate[0]),
      .phase_clr   (phase_clr_c[g]),
      .wave        (regs_q[g].wave),
      .pulse_width (regs_q[g].pulse_width),
      .incr        (ACC_W'({regs_q[g].incr_hi, regs_q[g].incr_lo})),
      .sample      (voice_sample[g])
    );
  end

  assign bus.BusReadData = rdata_q;
  assign Waveform        = mix_q;
  assign VoiceActive     = active_q;

endmodule

// File: doc/osc_bank.md
# osc_bank

Parametrised multi-voice oscillator bank with a memory-mapped control bus and an internal mixer. It replaces the single-voice oscillator behind `TopLevel`. `VOICES` independent phase-accumulator voices each produce saw, square, triangle or noise, and the mixer averages them into one `Waveform` sample stream for the DAC/display path. Per-voice registers are written and read back over the existing strobe-based bus.

## Interface
- `VOICES`, 4: voice count; a power of two in 1..8.
- `OUT_W`, 8: sample width of each voice and of `Waveform`.
- `ACC_W`, 16: phase accumulator width; must be ≥ `OUT_W` and ≥ 8.
- `BASE_ADDR`, 16'h0010: bus address of voice 0, offset 0.
- `Clock`  in  1: system clock. Sole clock domain.
- `Reset`  in  1: synchronous reset, active-low.
- `BusAddress`  in  16: register address.
- `BusWriteData`  in  8: write data.
- `BusReadData`  out  8: registered read data.
- `BusReadWrite`  in  1: 1 = write, 0 = read.
- `BusClock`  in  1: asynchronous bus strobe; its rising edge commits a write.
- `Waveform`  out  OUT_W: mixed output sample.
- `VoiceActive`  out  VOICES: per-voice gate bits.

## Operation
- Register map for voice v: address = `BASE_ADDR` + 8·v + offset.
  - 0 IncrLo
  - 1 Gate: bit0 = gate, bit1 = phase-reset-on-gate
  - 2 WaveType: 00 saw, 01 square, 10 triangle, 11 noise
  - 3 PulseWidth
  - 4 IncrHi
  - 5–7 reserved: writes ignored, reads return 0.
- Incr = {IncrHi, IncrLo}, zero-extended or truncated to `ACC_W`.
- Addresses outside the map: writes ignored, reads return 8'h00.
- Bus write path:
  - `BusClock` passes a 2-FF synchroniser, then an edge detector.
  - On a detected rising edge with `BusReadWrite`=1, the addressed register takes `BusWriteData`.
  - A rising edge with `BusReadWrite`=0 does nothing.
- Bus read path: every cycle, `BusReadData` is loaded with the register currently selected by `BusAddress`. No strobe is needed.
- Per voice, each cycle:
  - gate=1: phase ← phase + Incr, modulo 2^ACC_W.
  - gate=0: phase holds.
- Phase reset: a Gate write that takes bit0 from 0 to 1 while bit1 of the written value is 1 clears phase to 0 in the same cycle. This write beats the accumulate.
- Shaping, with p = top `OUT_W` bits of phase and p8 = top 8 bits:
  - saw: p.
  - square: all-ones if p8 < PulseWidth, else 0. PulseWidth 0 gives constant 0.
  - triangle: p[MSB]=0 → p<<1; p[MSB]=1 → ~(p<<1).
  - noise: top `OUT_W` bits of a per-voice 16-bit Fibonacci LFSR, taps 16,14,13,11. The LFSR advances only on accumulator carry-out.
- A voice with gate=0 outputs 0.
- Mixer: sum of all voice outputs in `OUT_W`+log2(`VOICES`) bits, then shifted right by log2(`VOICES`). No clipping is possible.

## Timing
- Reset (`Reset`=0 at a `Clock` edge) sets:
  - all registers, phases, synchroniser and edge flops, `Waveform`, `BusReadData` and `VoiceActive` to 0;
  - the voice v LFSR to 16'hACE1 ^ v.
- Reset asserted mid-transaction: a pending strobe edge is discarded.
- Write latency: a register holds its new value at most 4 `Clock` cycles after `BusClock` rises. `BusAddress` and `BusWriteData` must stay stable from the `BusClock` rise for 4 cycles.
- Strobe rate: `BusClock` high and low phases must each be ≥ 2 `Clock` cycles. Faster strobes are unsupported.
- Read latency: 1 cycle from an address change.
- Output pipeline:
  - The phase register feeds a registered voice sample (+1 cycle).
  - The voice sample feeds a registered mix (+1 cycle).
  - `Waveform` therefore lags phase by 2 cycles.
- `VoiceActive` is registered and mirrors gate bits with 1-cycle lag.
- An Incr write takes effect on the accumulate in the cycle after the register update. No glitch occurs from a half-written 16-bit increment beyond one IncrLo/IncrHi step.

## Structure
- `synth_pkg` holds:
  - the wave-type enum;
  - register offset constants and the stride of 8;
  - the LFSR seed and taps;
  - a `clog2` helper.
- Sub-module `synth_voice`: accumulator, phase-reset logic, LFSR and shaper. It is instantiated `VOICES` times by a generate loop.
- `osc_bank` holds the bus synchroniser, address decode, register file, readback mux and mixer.

## Test plan
- **Reset:** hold `Reset`=0 for 5 cycles → `Waveform`=0, `BusReadData`=0, `VoiceActive`=0.
- **Saw:**
  - Stimulus (voice 0): write IncrLo 8'h00, IncrHi 8'h01, WaveType 00, Gate 01.
  - Required: `Waveform` = (cycle count) / 4 with `VOICES`=4, wrapping every 256 cycles.
- **Square:**
  - Stimulus (voice 1 at 16'h0018): Incr 16'h0100, WaveType 01, PulseWidth 8'h40, Gate 01.
  - Required: the voice is high for 64 of every 256 cycles; `Waveform` toggles between 0 and 8'h3F.
- **Phase reset:**
  - Stimulus: a running voice; write Gate 00, then Gate 03.
  - Required: phase is 0 on the gate cycle and the first saw sample after the 2-cycle latency is 0.
- **Readback and unmapped access:**
  - Stimulus: write PulseWidth 8'h7F, then read 16'h0013; then read 16'h0005 and 16'h0036 (`VOICES`=4).
  - Required: 16'h0013 returns 8'h7F; 16'h0005 and 16'h0036 return 8'h00.
- **Full mix:**
  - Stimulus: all 4 voices on square, PulseWidth 8'hFF, Incr 1.
  - Required: `Waveform`=8'hFF once steady. Gate voice 3 off → 8'hBF within 6 cycles of the committed write.
